seq_shifter: RTL and testbench

- Parametrised multi-cycle barrel-shift replacement that shifts a WIDTH-bit operand by a run-time amount, one bit position per clock.
- Supports four modes: logical left, logical right, arithmetic right, rotate left.
- Uses a start/busy/done handshake.
- Sits beside address and datapath logic that needs variable shifts without the area of a combinational barrel shifter.

---
 rtl/seq_shifter.sv | 108 ++++++++++
 tb/tb_seq_shifter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts a WIDTH-bit operand by a run-time amount, one bit per clock,
// in LSL/LSR/ASR/ROL modes behind a start/busy/done handshake.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } mode_t;

    localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

    state_t             state;
    state_t             state_next;
    mode_t              mode_q;
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step;
    logic               accept;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero shift amount skips SHIFT entirely so the result appears one cycle after start.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        step = work;
        case (mode_q)
            LSL:     step = {work[WIDTH-2:0], 1'b0};
            LSR:     step = {1'b0, work[WIDTH-1:1]};
            ASR:     step = {work[WIDTH-1], work[WIDTH-1:1]};
            ROL:     step = {work[WIDTH-2:0], work[WIDTH-1]};
            default: step = work;
        endcase
    end

    // The working register doubles as the result, so it holds its value after DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            work   <= '0;
            count  <= '0;
            mode_q <= LSL;
        end else if (accept) begin
            work   <= data_in;
            count  <= shamt;
            mode_q <= mode_t'(mode);
        end else if (state == SHIFT) begin
            work  <= step;
            count <= count - ONE;
        end
    end

    assign data_out = work;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: stimulus queues expected results and done cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_seq_shifter;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        string       name;
    } expect_t;

    expect_t scoreboard[$];
    int      cyc;
    int      checks;
    int      errors;

    seq_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives a one-cycle start pulse and returns at the negedge of the accepting cycle.
    task automatic applyStimulus(input string name, input logic [31:0] d, input logic [4:0] s,
                                 input logic [1:0] m, input logic [31:0] expected);
        expect_t e;
        @(negedge clock);
        start   = 1'b1;
        data_in = d;
        shamt   = s;
        mode    = m;
        e.data  = expected;
        e.cyc   = cyc + 1 + int'(s);
        e.name  = name;
        scoreboard.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((busy || scoreboard.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: busy=%0b pending=%0d, expected idle with none pending",
                     name, busy, scoreboard.size());
            scoreboard.delete();
        end
    endtask

    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected done at cycle %0d: got done=1, expected 0", cyc);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput({e.name, " data"}, data_out, e.data);
                checkOutput({e.name, " done cycle"}, 32'(cyc), 32'(e.cyc));
                checkOutput({e.name, " busy"}, {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        mode    = 2'b00;
        repeat (3) @(negedge clock);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset data_out", data_out, 32'd0);
        reset = 1'b0;

        applyStimulus("lsl1", 32'h0001E677, 5'd1, 2'b00, 32'h0003CCEE);
        checkOutput("lsl1 busy c1", {31'd0, busy}, 32'd1);
        @(negedge clock);
        checkOutput("lsl1 busy c2", {31'd0, busy}, 32'd1);
        @(negedge clock);
        checkOutput("lsl1 busy c3", {31'd0, busy}, 32'd0);
        waitIdle("lsl1");

        applyStimulus("lsr1", 32'h0001E677, 5'd1, 2'b01, 32'h0000F33B);
        waitIdle("lsr1");
        applyStimulus("asr4", 32'h80000000, 5'd4, 2'b10, 32'hF8000000);
        waitIdle("asr4");
        applyStimulus("rol1", 32'h80000001, 5'd1, 2'b11, 32'h00000003);
        waitIdle("rol1");
        applyStimulus("rol31", 32'h12345678, 5'd31, 2'b11, 32'h091A2B3C);
        waitIdle("rol31");
        applyStimulus("lsl31", 32'hFFFFFFFF, 5'd31, 2'b00, 32'h80000000);
        waitIdle("lsl31");

        applyStimulus("zero", 32'd34475, 5'd0, 2'b10, 32'd34475);
        checkOutput("zero busy c1", {31'd0, busy}, 32'd1);
        start   = 1'b1;
        data_in = 32'hDEADBEEF;
        shamt   = 5'd2;
        @(negedge clock);
        start = 1'b0;
        checkOutput("zero busy c2", {31'd0, busy}, 32'd0);
        checkOutput("zero hold", data_out, 32'd34475);
        repeat (6) @(negedge clock);
        waitIdle("zero");

        start   = 1'b1;
        data_in = 32'hFFFFFFFF;
        shamt   = 5'd20;
        mode    = 2'b00;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort data_out", data_out, 32'd0);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        applyStimulus("after reset", 32'h0000F0F0, 5'd4, 2'b01, 32'h00000F0F);
        waitIdle("after reset");

        begin
            expect_t e;
            int      c0;
            @(negedge clock);
            start   = 1'b1;
            data_in = 32'h0000000F;
            shamt   = 5'd3;
            mode    = 2'b00;
            c0      = cyc + 1;
            for (int k = 0; k < 3; k++) begin
                e.data = 32'h00000078;
                e.cyc  = c0 + 3 + 5 * k;
                e.name = $sformatf("hold%0d", k);
                scoreboard.push_back(e);
            end
            for (int n = 0; n < 14; n++) begin
                @(negedge clock);
                if (n == 4) begin
                    checkOutput("hold idle busy", {31'd0, busy}, 32'd0);
                    checkOutput("hold idle data", data_out, 32'h00000078);
                end
            end
            start = 1'b0;
            waitIdle("hold");
        end

        repeat (5) @(negedge clock);
        checkOutput("pending at end", 32'(scoreboard.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
